sample_source_arbiter: RTL and testbench

- Shares the single sample FIFO write port among NREQ sample producers in the clk domain: the APD timer plus status/marker record generators.
- Round-robin grant with a req/ack handshake per source.
- One-entry output register drives the FIFO write side and honours the FIFO full flag, so no sample is ever lost.
- Sits between the producers and sample_fifo; the FIFO write count for the length summator is taken from fifo_wrreq.

---
 rtl/sample_source_arbiter_pkg.sv | 15 +
 rtl/sample_source_arbiter_rr_pick.sv | 32 +++
 rtl/sample_source_arbiter.sv | 89 ++++++++
 tb/tb_sample_source_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_source_arbiter_pkg.sv
// Shared definitions for the sample FIFO write-port arbiter and its producers.
package sample_source_arbiter_pkg;

  localparam int SAMPLE_WIDTH       = 48;
  localparam int NUM_SAMPLE_SOURCES = 4;

  // Fixed request-port assignment of the sample producers.
  typedef enum logic [1:0] {
    SRC_APD_TIMER = 2'd0,
    SRC_MARKER    = 2'd1,
    SRC_STATUS    = 2'd2,
    SRC_SPARE     = 2'd3
  } sample_source_e;

endpackage

// File: rtl/sample_source_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit strictly after last_grant,
// wrapping to the lowest index. Shared with the command-ack arbitration.
module sample_source_arbiter_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDXW = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] last_grant,
  output logic [IDXW-1:0] winner,
  output logic            found
);

  always_comb begin
    // NOTE: every output gets a default before the loops so no path leaves it unassigned (no latch).
    winner = '0;
    found  = 1'b0;
    // Wrap candidate: lowest requesting index overall.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        winner = IDXW'(i);
        found  = 1'b1;
      end
    end
    // Preferred candidate: lowest requesting index above last_grant overrides the wrap.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i] && (IDXW'(i) > last_grant)) begin
        winner = IDXW'(i);
      end
    end
  end

endmodule

// File: rtl/sample_source_arbiter.sv
// Round-robin arbiter sharing the sample FIFO write port among NREQ producers.
// Optional backpressure counter enabled with `define ARB_STALL_COUNT_EN.
module sample_source_arbiter
  import sample_source_arbiter_pkg::*;
#(
  parameter int NREQ  = NUM_SAMPLE_SOURCES,
  parameter int WIDTH = SAMPLE_WIDTH,
  parameter int IDXW  = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] sample_in,
  output logic [NREQ-1:0]       ack,
  input  logic                  fifo_full,
  output logic                  fifo_wrreq,
  output logic [WIDTH-1:0]      fifo_data,
  output logic [IDXW-1:0]       last_grant,
  output logic                  busy
`ifdef ARB_STALL_COUNT_EN
  ,
  input  logic                  stall_clr,
  output logic [15:0]           stall_count
`endif
);

  logic            accept;
  logic            grant;
  logic            found;
  logic [IDXW-1:0] winner;
  logic [WIDTH-1:0] win_data;

  sample_source_arbiter_rr_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_rr_pick (
    .req        (req),
    .last_grant (last_grant),
    .winner     (winner),
    .found      (found)
  );

  // The stage can take a new sample when empty or when its content leaves this cycle.
  assign accept     = ~busy | ~fifo_full;
  assign grant      = enable & accept & found;
  assign fifo_wrreq = busy & ~fifo_full;

  always_comb begin
    ack      = '0;
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == IDXW'(i)) begin
        ack[i]   = grant;
        win_data = sample_in[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: the data register is reset too, so fifo_data reads zero rather than X after reset.
    if (!reset_n) begin
      fifo_data  <= '0;
      busy       <= 1'b0;
      last_grant <= IDXW'(NREQ - 1);
    end else if (grant) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      fifo_data  <= win_data;
      busy       <= 1'b1;
      last_grant <= winner;
    end else if (fifo_wrreq) begin
      busy <= 1'b0;
    end
  end

`ifdef ARB_STALL_COUNT_EN
  // Counts cycles where a source wants the stage but the full FIFO blocks it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= '0;
    end else if (stall_clr) begin
      stall_count <= '0;
    end else if ((|req) && enable && !accept && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sample_source_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// behavioural round-robin/one-slot-buffer model.
module tb_sample_source_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 48;
  localparam int IDXW  = 3;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  enable;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] sample_in;
  logic [NREQ-1:0]       ack;
  logic                  fifo_full;
  logic                  fifo_wrreq;
  logic [WIDTH-1:0]      fifo_data;
  logic [IDXW-1:0]       last_grant;
  logic                  busy;
`ifdef ARB_STALL_COUNT_EN
  logic                  stall_clr;
  logic [15:0]           stall_count;
`endif

  sample_source_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDXW(IDXW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .req        (req),
    .sample_in  (sample_in),
    .ack        (ack),
    .fifo_full  (fifo_full),
    .fifo_wrreq (fifo_wrreq),
    .fifo_data  (fifo_data),
    .last_grant (last_grant),
    .busy       (busy)
`ifdef ARB_STALL_COUNT_EN
    ,
    .stall_clr  (stall_clr),
    .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: one-slot buffer plus round-robin pointer.
  bit               m_busy;
  logic [WIDTH-1:0] m_data;
  int               m_last;
  int               m_stall;

  int               ack_log[$];
  logic [WIDTH-1:0] wr_log[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_src(input int i, input logic [WIDTH-1:0] v);
    sample_in[i*WIDTH +: WIDTH] = v;
  endtask

  function automatic logic [WIDTH-1:0] rand_sample();
    return {$urandom(), $urandom()} & {WIDTH{1'b1}};
  endfunction

  task automatic model_reset();
    m_busy  = 1'b0;
    m_data  = '0;
    m_last  = NREQ - 1;
    m_stall = 0;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    int               w;
    bit               room;
    bit               e_wr;
    logic [NREQ-1:0]  e_ack;
    logic [WIDTH-1:0] taken;
    #1;
    room = !m_busy || !fifo_full;
    w = -1;
    for (int k = 1; k <= NREQ; k++) begin
      if (w < 0 && (((req >> ((m_last + k) % NREQ)) & NREQ'(1)) != '0)) w = (m_last + k) % NREQ;
    end
    e_ack = (w >= 0 && enable && room) ? (NREQ'(1) << w) : '0;
    e_wr  = m_busy && !fifo_full;
    taken = (w >= 0) ? sample_in[w*WIDTH +: WIDTH] : '0;
    check("ack", 64'(ack), 64'(e_ack));
    check("fifo_wrreq", 64'(fifo_wrreq), 64'(e_wr));
    check("busy", 64'(busy), 64'(m_busy));
    check("fifo_data", 64'(fifo_data), 64'(m_data));
    check("last_grant", 64'(last_grant), 64'(m_last));
`ifdef ARB_STALL_COUNT_EN
    check("stall_count", 64'(stall_count), 64'(m_stall));
`endif
    if (fifo_wrreq === 1'b1) wr_log.push_back(fifo_data);
    if (e_ack != '0) ack_log.push_back(w);
    @(posedge clk);
`ifdef ARB_STALL_COUNT_EN
    if (stall_clr) m_stall = 0;
    else if (req != '0 && enable && !room && m_stall < 65535) m_stall++;
`endif
    if (e_ack != '0) begin
      m_data = taken;
      m_busy = 1'b1;
      m_last = w;
    end else if (e_wr) begin
      m_busy = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_wrreq", 64'(fifo_wrreq), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_data", 64'(fifo_data), 64'd0);
    check("rst_last_grant", 64'(last_grant), 64'(NREQ - 1));
    check("rst_ack", 64'(ack), 64'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [WIDTH-1:0] held;
    logic [WIDTH-1:0] sa, sb, sc;
    int               lg;

    reset_n   = 1'b0;
    enable    = 1'b1;
    req       = '0;
    sample_in = '0;
    fifo_full = 1'b0;
`ifdef ARB_STALL_COUNT_EN
    stall_clr = 1'b0;
`endif
    model_reset();
    @(negedge clk);
    do_reset();

    // Single source: same-cycle ack, next-cycle write, then idle.
    req = 4'b0001;
    set_src(0, 48'hfeeddeadbeed);
    #1;
    check("single_ack", 64'(ack), 64'h1);
    step();
    req = '0;
    #1;
    check("single_wrreq", 64'(fifo_wrreq), 64'd1);
    check("single_data", 64'(fifo_data), 64'hfeeddeadbeed);
    step();
    step();
    check("single_idle_busy", 64'(busy), 64'd0);

    // All four sources held: strict rotation, one write per cycle.
    do_reset();
    ack_log.delete();
    wr_log.delete();
    for (int i = 0; i < NREQ; i++) set_src(i, rand_sample());
    req = 4'b1111;
    for (int n = 0; n < 8; n++) begin
      step();
      if (ack_log.size() > 0) set_src(ack_log[ack_log.size() - 1], rand_sample());
    end
    req = '0;
    step();
    check("rot_ack_count", 64'(ack_log.size()), 64'd8);
    for (int n = 0; n < ack_log.size(); n++) check("rot_order", 64'(ack_log[n]), 64'(n % NREQ));
    check("rot_write_count", 64'(wr_log.size()), 64'd8);

    // Backpressure: full FIFO freezes the stage and blocks acks.
    req = 4'b0110;
    set_src(1, rand_sample());
    set_src(2, rand_sample());
`ifdef ARB_STALL_COUNT_EN
    stall_clr = 1'b1;
`endif
    step();
`ifdef ARB_STALL_COUNT_EN
    stall_clr = 1'b0;
`endif
    held = fifo_data;
    fifo_full = 1'b1;
    for (int n = 0; n < 5; n++) begin
      #1;
      check("bp_ack", 64'(ack), 64'd0);
      check("bp_data_stable", 64'(fifo_data), 64'(held));
      step();
    end
`ifdef ARB_STALL_COUNT_EN
    check("bp_stall_count", 64'(stall_count), 64'd5);
`endif
    fifo_full = 1'b0;
    #1;
    check("bp_release_wrreq", 64'(fifo_wrreq), 64'd1);
    check("bp_release_data", 64'(fifo_data), 64'(held));
    step();
    req = '0;
    step();
    step();

    // Back-to-back from source 2 alone: A, B, C with no bubble.
    wr_log.delete();
    sa = 48'h0000_0000_00a1;
    sb = 48'h0000_0000_00b2;
    sc = 48'h0000_0000_00c3;
    req = 4'b0100;
    set_src(2, sa);
    step();
    set_src(2, sb);
    step();
    set_src(2, sc);
    step();
    req = '0;
    step();
    step();
    check("b2b_count", 64'(wr_log.size()), 64'd3);
    if (wr_log.size() == 3) begin
      check("b2b_a", 64'(wr_log[0]), 64'(sa));
      check("b2b_b", 64'(wr_log[1]), 64'(sb));
      check("b2b_c", 64'(wr_log[2]), 64'(sc));
    end

    // enable dropped after an ack: sample drains, no new acks, pointer kept.
    req = 4'b0001;
    set_src(0, rand_sample());
    step();
    enable = 1'b0;
    req = 4'b1111;
    #1;
    lg = int'(last_grant);
    check("en_off_ack", 64'(ack), 64'd0);
    check("en_off_wrreq", 64'(fifo_wrreq), 64'd1);
    step();
    step();
    step();
    check("en_off_last_grant", 64'(last_grant), 64'(lg));
    enable = 1'b1;
    #1;
    check("en_resume_ack", 64'(ack), 64'(NREQ'(1) << ((lg + 1) % NREQ)));
    step();
    req = '0;
    step();
    step();

    // Reset while busy and stalled: output drops immediately.
    req = 4'b0001;
    step();
    fifo_full = 1'b1;
    req = '0;
    step();
    do_reset();
    fifo_full = 1'b0;
    req = 4'b1010;
    #1;
    check("post_rst_ack", 64'(ack), 64'h2);
    step();
    req = '0;
    step();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      req       = NREQ'($urandom());
      fifo_full = ($urandom_range(0, 3) == 0);
      enable    = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < NREQ; i++) set_src(i, rand_sample());
`ifdef ARB_STALL_COUNT_EN
      stall_clr = ($urandom_range(0, 31) == 0);
`endif
      step();
    end
    req       = '0;
    fifo_full = 1'b0;
    enable    = 1'b1;
`ifdef ARB_STALL_COUNT_EN
    stall_clr = 1'b0;
`endif
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
